// File: rtl/ssd_pkg.sv
// Shared types, segment constants and sizing helpers for the seven-segment scan driver.
package ssd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   // BCD bits for a data_w-bit binary value: 4 * ceil((data_w + 2) / 3), never truncates.
   function automatic int bcd_width(input int data_w);
      return 4 * ((data_w + 4) / 3);
   endfunction

endpackage

// File: rtl/ssd_seg_decoder.sv
// Nibble to active-low {g,f,e,d,c,b,a} pattern for a common-anode digit.
// The minus flag takes priority over blank, which takes priority over the nibble.
module ssd_seg_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       minus,
   output logic [6:0] seg
);

   logic [6:0] glyph;

   always_comb begin
      glyph = SEG_BLANK;
      case (nibble)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         4'hF: glyph = 7'b0001110;
         default: glyph = SEG_BLANK;
      endcase
      if (minus)
         seg = SEG_MINUS;
      else if (blank)
         seg = SEG_BLANK;
      else
         seg = glyph;
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Captures a value on load, converts it to decimal (shift-add-3) or hex digits,
// and time-multiplexes the committed digits onto active-low anode/cathode lines.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int DATA_W      = 13,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] value,
   input  logic              load,
   input  logic              hex_mode,
   input  logic              signed_mode,
   output logic [DIGITS-1:0] anode,
   output logic [6:0]        cathode,
   output logic              dp,
   output logic              busy,
   output logic              overflow
);

   localparam int BCD_W = bcd_width(DATA_W);
   localparam int NBCD  = BCD_W / 4;
   localparam int NPAD  = (NBCD > DIGITS) ? NBCD : DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                ovf_q, ovf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   mag_q, mag_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic                neg_q, neg_d;
   logic                hex_q, hex_d;
   logic [4*DIGITS-1:0] dig_nib_q, dig_nib_d;
   logic [DIGITS-1:0]   dig_blank_q, dig_blank_d;
   logic [DIGITS-1:0]   dig_minus_q, dig_minus_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]          cathode_q, cathode_d;

   logic [BCD_W-1:0]    bcd_adj;
   logic [4*NPAD-1:0]   src_nibs;
   logic                new_ovf;
   logic [4*DIGITS-1:0] new_nib;
   logic [DIGITS-1:0]   new_blank;
   logic [DIGITS-1:0]   new_minus;
   logic                seen_nz;
   logic [6:0]          seg;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NBCD; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Digit image for COMMIT; a negative value reserves the top digit for the minus sign.
   always_comb begin
      src_nibs = '0;
      if (hex_q)
         src_nibs[DATA_W-1:0] = mag_q;
      else
         src_nibs[BCD_W-1:0] = bcd_q;
      new_ovf = 1'b0;
      for (int i = 0; i < NPAD; i++) begin
         if ((i >= DIGITS || (neg_q && i == DIGITS - 1)) && src_nibs[4*i +: 4] != 4'd0)
            new_ovf = 1'b1;
      end
      seen_nz   = 1'b0;
      new_nib   = '0;
      new_blank = '0;
      new_minus = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         new_nib[4*i +: 4] = src_nibs[4*i +: 4];
         if (new_ovf || (neg_q && i == DIGITS - 1)) begin
            new_minus[i] = 1'b1;
         end else begin
            if (src_nibs[4*i +: 4] != 4'd0)
               seen_nz = 1'b1;
            if (BLANK_LZ != 0 && !seen_nz && i != 0)
               new_blank[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      mag_d       = mag_q;
      bcd_d       = bcd_q;
      neg_d       = neg_q;
      hex_d       = hex_q;
      dig_nib_d   = dig_nib_q;
      dig_blank_d = dig_blank_q;
      dig_minus_d = dig_minus_q;
      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               busy_d = 1'b1;
               hex_d  = hex_mode;
               cnt_d  = '0;
               bcd_d  = '0;
               if (hex_mode) begin
                  mag_d   = value;
                  neg_d   = 1'b0;
                  state_d = ST_COMMIT;
               end else begin
                  neg_d   = signed_mode & value[DATA_W-1];
                  mag_d   = (signed_mode && value[DATA_W-1]) ? ('0 - value) : value;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1))
               state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            dig_nib_d   = new_nib;
            dig_blank_d = new_blank;
            dig_minus_d = new_minus;
            ovf_d       = new_ovf;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   ssd_seg_decoder u_seg_decoder (
      .nibble (dig_nib_q[4*idx_q +: 4]),
      .blank  (dig_blank_q[idx_q]),
      .minus  (dig_minus_q[idx_q]),
      .seg    (seg)
   );

   // Scan keeps running during conversion, so it always shows the last committed digits.
   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
      if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      anode_d   = ~(DIGITS'(1) << idx_q);
      cathode_d = seg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         mag_q       <= '0;
         bcd_q       <= '0;
         neg_q       <= 1'b0;
         hex_q       <= 1'b0;
         dig_nib_q   <= '0;
         dig_blank_q <= '1;
         dig_minus_q <= '0;
         pre_q       <= '0;
         idx_q       <= '0;
         anode_q     <= '1;
         cathode_q   <= SEG_BLANK;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         mag_q       <= mag_d;
         bcd_q       <= bcd_d;
         neg_q       <= neg_d;
         hex_q       <= hex_d;
         dig_nib_q   <= dig_nib_d;
         dig_blank_q <= dig_blank_d;
         dig_minus_q <= dig_minus_d;
         pre_q       <= pre_d;
         idx_q       <= idx_d;
         anode_q     <= anode_d;
         cathode_q   <= cathode_d;
      end
   end

   assign anode    = anode_q;
   assign cathode  = cathode_q;
   assign dp       = 1'b1;
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule
